hiscore_ram_arbiter: RTL and testbench
======================================

Name: hiscore_ram_arbiter

Overview:
- Shares the game's high-score RAM port between the core CPU and the hiscore engine.
- When the hiscore engine raises its access request, the block pauses the CPU and waits a settle time. It then hands the RAM address, data and write-enable to the hiscore engine.
- When the request drops, it gives the port back after a release guard.
- Sits between the hiscore engine and the core's work-RAM mux, inside the arcade top level.

Parameters:
- ADDR_WIDTH, 10, width of the game RAM address.
- SETTLE_CYCLES, 4, cycles the CPU is held paused before the grant (1..255).
- RELEASE_CYCLES, 2, cycles the pause is held after the grant ends (0..255).
- TIMEOUT_CYCLES, 65535, maximum grant length; used only when HS_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- hs_access  in  1  hiscore engine requests the RAM port (level)
- hs_write  in  1  hiscore write strobe; honoured only while hs_grant=1
- hs_addr  in  ADDR_WIDTH  hiscore RAM address
- hs_dout  in  8  hiscore write data
- hs_din  out  8  RAM read data returned to the hiscore engine (passes ram_q straight through)
- hs_grant  out  1  hiscore engine owns the port
- core_addr  in  ADDR_WIDTH  CPU RAM address
- core_dout  in  8  CPU write data
- core_we  in  1  CPU write enable
- user_pause  in  1  OSD/user pause request
- ram_addr  out  ADDR_WIDTH  muxed RAM address
- ram_din  out  8  muxed RAM write data
- ram_we  out  1  muxed RAM write enable
- ram_q  in  8  RAM read data
- cpu_pause  out  1  pause the CPU (registered)
- hs_error  out  1  sticky timeout flag (driven 0 when the optional feature is absent)

Behaviour:
- Reset (async, reset_n=0): state=IDLE, cpu_pause=0, hs_grant=0, counters=0, hs_error=0. Reset mid-grant returns the port to the CPU immediately.
- Mux (combinational on registered hs_grant):
  - hs_grant=1: ram_addr=hs_addr, ram_din=hs_dout, ram_we=hs_write.
  - hs_grant=0: ram_addr=core_addr, ram_din=core_dout, ram_we=core_we & ~cpu_pause.
  - CPU writes are therefore blocked from the first cycle of pause.
- cpu_pause = user_pause_r | arb_pause, where both terms are registered (1 cycle latency from user_pause).
- FSM:
  - IDLE: arb_pause=0. hs_access=1 -> PAUSE; cnt loads SETTLE_CYCLES-1; arb_pause rises next cycle.
  - PAUSE: arb_pause=1. If hs_access drops -> RELEASE. Else when cnt=0 -> GRANT, hs_grant=1 next cycle. Else cnt decrements.
  - GRANT: arb_pause=1, hs_grant=1. When hs_access=0 -> RELEASE: hs_grant=0 next cycle, cnt loads RELEASE_CYCLES.
  - RELEASE: arb_pause=1, hs_grant=0. When cnt=0 -> IDLE, arb_pause=0 next cycle. Else cnt decrements. A new hs_access arriving in RELEASE goes straight to PAUSE with a full settle reload.
- Latency: hs_access rising to hs_grant=1 is SETTLE_CYCLES+1 cycles.
- With RELEASE_CYCLES=0, RELEASE lasts exactly 1 cycle.
- user_pause asserted when the request arrives: the settle still runs in full (no bypass).
- user_pause toggling during GRANT has no effect on the grant.
- hs_write while hs_grant=0 is ignored.
- hs_access and hs_write are assumed synchronous to clk.

Optional Feature:
- HS_ARB_TIMEOUT_EN defined:
  - A 16-bit grant counter clears on entry to GRANT and increments each GRANT cycle.
  - On reaching TIMEOUT_CYCLES: force RELEASE, set hs_error (sticky until reset).
  - Then ignore hs_access until it has been seen low for at least one cycle.
- Not defined: no counter; GRANT lasts as long as hs_access; hs_error tied 0.

Decomposition:
- Package hiscore_pkg holds:
  - arb_state_t enum {IDLE, PAUSE, GRANT, RELEASE};
  - localparam widths for the settle, release and timeout counters.
- One sub-module, hiscore_arb_mux: the combinational port mux, also reused by cores with two RAM banks.
- FSM and counters stay in hiscore_ram_arbiter.

Test Plan:
- Basic grant, SETTLE_CYCLES=4: hs_access=1 at cycle 0 -> cpu_pause=1 at cycle 1; hs_grant=1 at cycle 5; ram_addr follows hs_addr=0x123.
- Hiscore write under grant: hs_write=1, hs_addr=0x040, hs_dout=0xA5 -> ram_we=1, ram_addr=0x040, ram_din=0xA5 the same cycle. Concurrent core_we=1 is not forwarded.
- Release, RELEASE_CYCLES=2: drop hs_access in GRANT -> hs_grant=0 next cycle; cpu_pause falls 3 cycles after that; ram_addr returns to core_addr.
- Abort during settle: hs_access high for 2 cycles then low -> hs_grant never asserts; FSM passes RELEASE -> IDLE; cpu_pause back to 0.
- Async reset mid-GRANT: reset_n=0 -> hs_grant=0 and cpu_pause=0 without waiting for a clock; ram_we=core_we.
- HS_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and hs_access held high -> forced release after 16 grant cycles, hs_error=1, no re-grant until hs_access toggles low then high.

Source files
------------

// File: rtl/hiscore_pkg.sv
// Shared types and counter widths for the hiscore RAM arbiter and its port mux.
// The optional grant timeout is enabled with the HS_ARB_TIMEOUT_EN macro.
package hiscore_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAUSE   = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam int SETTLE_CNT_W  = 8;
  localparam int RELEASE_CNT_W = 8;
  localparam int TIMEOUT_CNT_W = 16;

  // Settle and release phases share one down-counter sized for the wider of the two.
  localparam int CNT_W = (SETTLE_CNT_W > RELEASE_CNT_W) ? SETTLE_CNT_W : RELEASE_CNT_W;

endpackage

// File: rtl/hiscore_arb_mux.sv
// Combinational RAM port mux: the hiscore engine owns the port while granted,
// otherwise the CPU does, with CPU writes suppressed whenever the CPU is paused.
module hiscore_arb_mux #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  grant_i,
  input  logic                  cpu_pause_i,
  input  logic [ADDR_WIDTH-1:0] hs_addr_i,
  input  logic [7:0]            hs_dout_i,
  input  logic                  hs_write_i,
  input  logic [ADDR_WIDTH-1:0] core_addr_i,
  input  logic [7:0]            core_dout_i,
  input  logic                  core_we_i,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [7:0]            ram_din_o,
  output logic                  ram_we_o
);

  always_comb begin
    if (grant_i) begin
      ram_addr_o = hs_addr_i;
      ram_din_o  = hs_dout_i;
      ram_we_o   = hs_write_i;
    end else begin
      ram_addr_o = core_addr_i;
      ram_din_o  = core_dout_i;
      ram_we_o   = core_we_i & ~cpu_pause_i;
    end
  end

endmodule

// File: rtl/hiscore_ram_arbiter.sv
// Hands the high-score RAM port to the hiscore engine after pausing the CPU for a
// settle time, and returns it after a release guard. Optional grant timeout: HS_ARB_TIMEOUT_EN.
module hiscore_ram_arbiter
  import hiscore_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int SETTLE_CYCLES  = 4,
  parameter int RELEASE_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  hs_access,
  input  logic                  hs_write,
  input  logic [ADDR_WIDTH-1:0] hs_addr,
  input  logic [7:0]            hs_dout,
  output logic [7:0]            hs_din,
  output logic                  hs_grant,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [7:0]            core_dout,
  input  logic                  core_we,
  input  logic                  user_pause,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_din,
  output logic                  ram_we,
  input  logic [7:0]            ram_q,
  output logic                  cpu_pause,
  output logic                  hs_error
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LOAD = CNT_W'(RELEASE_CYCLES);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             user_pause_q;
  logic             access_eff;
  logic             timeout_hit;
  logic             arb_pause;

`ifdef HS_ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_CNT_W-1:0] gcnt_q, gcnt_d;
  logic                     lock_q, lock_d;
  logic                     hs_error_q, hs_error_d;

  // After a forced release the request is ignored until it has been seen low once.
  assign access_eff  = hs_access & ~lock_q;
  assign timeout_hit = (state_q == GRANT) && (gcnt_q == TIMEOUT_LAST);

  always_comb begin
    gcnt_d     = (state_q == GRANT) ? gcnt_q + 1'b1 : '0;
    hs_error_d = hs_error_q | timeout_hit;
    lock_d     = lock_q;
    if (timeout_hit)     lock_d = 1'b1;
    else if (!hs_access) lock_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gcnt_q     <= '0;
      lock_q     <= 1'b0;
      hs_error_q <= 1'b0;
    end else begin
      gcnt_q     <= gcnt_d;
      lock_q     <= lock_d;
      hs_error_q <= hs_error_d;
    end
  end

  assign hs_error = hs_error_q;
`else
  assign access_eff  = hs_access;
  assign timeout_hit = 1'b0;
  assign hs_error    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      user_pause_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      user_pause_q <= user_pause;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (access_eff) begin
          state_d = PAUSE;
          cnt_d   = SETTLE_LOAD;
        end
      end
      PAUSE: begin
        if (!access_eff) begin
          state_d = RELEASE;
          cnt_d   = RELEASE_LOAD;
        end else if (cnt_q == '0) begin
          state_d = GRANT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GRANT: begin
        if (!access_eff || timeout_hit) begin
          state_d = RELEASE;
          cnt_d   = RELEASE_LOAD;
        end
      end
      RELEASE: begin
        // A fresh request restarts the full settle rather than reusing the old grant.
        if (access_eff) begin
          state_d = PAUSE;
          cnt_d   = SETTLE_LOAD;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    arb_pause = (state_q != IDLE);
    hs_grant  = (state_q == GRANT);
    cpu_pause = user_pause_q | arb_pause;
    hs_din    = ram_q;
  end

  hiscore_arb_mux #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mux (
    .grant_i     (hs_grant),
    .cpu_pause_i (cpu_pause),
    .hs_addr_i   (hs_addr),
    .hs_dout_i   (hs_dout),
    .hs_write_i  (hs_write),
    .core_addr_i (core_addr),
    .core_dout_i (core_dout),
    .core_we_i   (core_we),
    .ram_addr_o  (ram_addr),
    .ram_din_o   (ram_din),
    .ram_we_o    (ram_we)
  );

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Directed bench for hiscore_ram_arbiter: mux vector table plus cycle-exact sequences.
module tb_hiscore_ram_arbiter;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          hs_access, hs_write, core_we, user_pause;
  logic [AW-1:0] hs_addr, core_addr;
  logic [7:0]    hs_dout, core_dout, ram_q;
  logic [7:0]    hs_din, ram_din;
  logic [AW-1:0] ram_addr;
  logic          hs_grant, ram_we, cpu_pause, hs_error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hiscore_ram_arbiter #(
    .ADDR_WIDTH     (AW),
    .SETTLE_CYCLES  (4),
    .RELEASE_CYCLES (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hs_access  (hs_access),
    .hs_write   (hs_write),
    .hs_addr    (hs_addr),
    .hs_dout    (hs_dout),
    .hs_din     (hs_din),
    .hs_grant   (hs_grant),
    .core_addr  (core_addr),
    .core_dout  (core_dout),
    .core_we    (core_we),
    .user_pause (user_pause),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_q      (ram_q),
    .cpu_pause  (cpu_pause),
    .hs_error   (hs_error)
  );

  typedef struct {
    logic          granted;
    logic          up;
    logic [AW-1:0] c_addr;
    logic [7:0]    c_dout;
    logic          c_we;
    logic [AW-1:0] h_addr;
    logic [7:0]    h_dout;
    logic          h_wr;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_din;
    logic          e_we;
    logic          e_pause;
    logic          e_grant;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic enter_grant();
    hs_access = 1'b1;
    repeat (5) step();
  endtask

  task automatic to_idle();
    hs_access = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    int gcycles;
    bit in_grant;

    vecs[0] = '{1'b0, 1'b0, 10'h2AA, 8'h11, 1'b1, 10'h155, 8'h22, 1'b1, 10'h2AA, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 10'h001, 8'hFF, 1'b0, 10'h155, 8'h22, 1'b1, 10'h001, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 10'h3FF, 8'h5A, 1'b1, 10'h0AA, 8'h44, 1'b0, 10'h3FF, 8'h5A, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 10'h100, 8'h80, 1'b1, 10'h0AA, 8'h44, 1'b0, 10'h100, 8'h80, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 10'h0F0, 8'h33, 1'b1, 10'h040, 8'hA5, 1'b1, 10'h040, 8'hA5, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 10'h0F0, 8'h33, 1'b1, 10'h3C3, 8'h0F, 1'b0, 10'h3C3, 8'h0F, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 10'h2F0, 8'h77, 1'b0, 10'h000, 8'h00, 1'b1, 10'h000, 8'h00, 1'b1, 1'b1, 1'b1};

    // clock/reset
    reset_n = 1'b0; hs_access = 1'b0; hs_write = 1'b0; core_we = 1'b0; user_pause = 1'b0;
    hs_addr = '0; core_addr = '0; hs_dout = '0; core_dout = '0; ram_q = 8'h3C;
    step(); step();
    chk("rst_grant", hs_grant, 0);
    chk("rst_pause", cpu_pause, 0);
    chk("rst_error", hs_error, 0);
    chk("hs_din_pass", hs_din, 8'h3C);
    reset_n = 1'b1;
    step();

    // mux vector table
    in_grant = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].granted && !in_grant) begin
        enter_grant();
        in_grant = 1'b1;
      end
      user_pause = vecs[i].up;
      core_addr = vecs[i].c_addr; core_dout = vecs[i].c_dout; core_we = vecs[i].c_we;
      hs_addr = vecs[i].h_addr; hs_dout = vecs[i].h_dout; hs_write = vecs[i].h_wr;
      step();
      chk($sformatf("v%0d_addr", i), ram_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_din", i), ram_din, vecs[i].e_din);
      chk($sformatf("v%0d_we", i), ram_we, vecs[i].e_we);
      chk($sformatf("v%0d_pause", i), cpu_pause, vecs[i].e_pause);
      chk($sformatf("v%0d_grant", i), hs_grant, vecs[i].e_grant);
    end
    hs_write = 1'b0; core_we = 1'b0; user_pause = 1'b0;
    to_idle();
    chk("tbl_idle_pause", cpu_pause, 0);

    // basic grant latency
    hs_addr = 10'h123; core_addr = 10'h2F0; core_dout = 8'h66;
    hs_access = 1'b1;
    #1 chk("bg_c0_pause", cpu_pause, 0);
    step();
    chk("bg_c1_pause", cpu_pause, 1);
    chk("bg_c1_grant", hs_grant, 0);
    step(); step(); step();
    chk("bg_c4_grant", hs_grant, 0);
    step();
    chk("bg_c5_grant", hs_grant, 1);
    chk("bg_c5_addr", ram_addr, 10'h123);

    // same-cycle hiscore write, core write blocked
    hs_write = 1'b1; hs_addr = 10'h040; hs_dout = 8'hA5; core_we = 1'b1;
    #1;
    chk("wr_we", ram_we, 1);
    chk("wr_addr", ram_addr, 10'h040);
    chk("wr_din", ram_din, 8'hA5);
    hs_write = 1'b0;
    #1 chk("wr_core_blocked", ram_we, 0);

    // release guard; hs_write ignored once the grant is gone
    hs_write = 1'b1; core_we = 1'b0;
    hs_access = 1'b0;
    step();
    chk("rel_grant", hs_grant, 0);
    chk("rel_addr", ram_addr, 10'h2F0);
    chk("rel_pause0", cpu_pause, 1);
    chk("rel_hswr_ignored", ram_we, 0);
    step();
    chk("rel_pause1", cpu_pause, 1);
    step();
    chk("rel_pause2", cpu_pause, 1);
    step();
    chk("rel_pause3", cpu_pause, 0);
    chk("rel_idle_we", ram_we, 0);
    hs_write = 1'b0;

    // abort during settle
    hs_access = 1'b1;
    step(); step();
    hs_access = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("ab_grant%0d", k), hs_grant, 0);
      chk($sformatf("ab_pause%0d", k), cpu_pause, 1);
    end
    step();
    chk("ab_pause_end", cpu_pause, 0);
    chk("ab_grant_end", hs_grant, 0);

    // re-request during release reloads the full settle
    enter_grant();
    hs_access = 1'b0;
    step();
    chk("rr_released", hs_grant, 0);
    hs_access = 1'b1;
    step(); step(); step(); step();
    chk("rr_s4_grant", hs_grant, 0);
    step();
    chk("rr_s5_grant", hs_grant, 1);

    // user_pause toggling under grant
    user_pause = 1'b1;
    step();
    chk("up_on_grant", hs_grant, 1);
    chk("up_on_pause", cpu_pause, 1);
    user_pause = 1'b0;
    step();
    chk("up_off_grant", hs_grant, 1);
    to_idle();

    // user_pause present when the request arrives: no settle bypass
    user_pause = 1'b1;
    step();
    chk("upr_pause", cpu_pause, 1);
    hs_access = 1'b1;
    step(); step(); step(); step();
    chk("upr_s4_grant", hs_grant, 0);
    step();
    chk("upr_s5_grant", hs_grant, 1);
    user_pause = 1'b0;

    // async reset mid-grant
    core_we = 1'b1; hs_write = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    chk("ar_grant", hs_grant, 0);
    chk("ar_pause", cpu_pause, 0);
    chk("ar_we", ram_we, 1);
    hs_access = 1'b0; core_we = 1'b0;
    step();
    reset_n = 1'b1;
    step();

`ifdef HS_ARB_TIMEOUT_EN
    // forced release after 16 grant cycles, then lockout until hs_access toggles
    hs_access = 1'b1;
    gcycles = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (hs_grant) gcycles++;
    end
    chk("to_grant_cycles", gcycles, 16);
    chk("to_error", hs_error, 1);
    chk("to_no_regrant", hs_grant, 0);
    chk("to_idle_pause", cpu_pause, 0);
    hs_access = 1'b0;
    step();
    hs_access = 1'b1;
    step(); step(); step(); step();
    chk("to_re_s4", hs_grant, 0);
    step();
    chk("to_re_s5", hs_grant, 1);
    chk("to_error_sticky", hs_error, 1);
    to_idle();
`else
    // long grant never times out without the option
    hs_access = 1'b1;
    gcycles = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (hs_grant) gcycles++;
    end
    chk("long_grant_cycles", gcycles, 56);
    chk("long_error", hs_error, 0);
    to_idle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
